// File: rtl/vga_scan_controller.sv
// Parametrised VGA raster front end: sync/blank timing, row/col/linear address
// from counters, and NUM_WIN overlay windows with per-window local pixel addresses.
module vga_scan_controller #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int NUM_WIN  = 4,
    parameter int COORD_W  = 10,
    parameter int ADDR_W   = 19,
    parameter int WADDR_W  = 18,
    parameter int FRAME_W  = 32
) (
    input  logic                                             iVGA_CLK,
    input  logic                                             reset,
    input  logic [NUM_WIN-1:0]                               win_en,
    input  logic [NUM_WIN*COORD_W-1:0]                       win_x0,
    input  logic [NUM_WIN*COORD_W-1:0]                       win_y0,
    input  logic [NUM_WIN*COORD_W-1:0]                       win_w,
    input  logic [NUM_WIN*COORD_W-1:0]                       win_h,
    output logic                                             oHS,
    output logic                                             oVS,
    output logic                                             oBLANK_n,
    output logic [COORD_W-1:0]                               row,
    output logic [COORD_W-1:0]                               col,
    output logic [ADDR_W-1:0]                                ADDR,
    output logic [NUM_WIN-1:0]                               win_hit,
    output logic                                             win_any,
    output logic [((NUM_WIN > 1) ? $clog2(NUM_WIN) : 1)-1:0] win_sel,
    output logic [NUM_WIN*WADDR_W-1:0]                       win_addr,
    output logic                                             frame_start,
    output logic [FRAME_W-1:0]                               frame_count
);

    localparam int SEL_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HC_W    = $clog2(H_TOTAL + 1);
    localparam int VC_W    = $clog2(V_TOTAL + 1);

    localparam logic [HC_W-1:0] H_ACT_C  = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] HS_BEG_C = HC_W'(H_ACTIVE + H_FP);
    localparam logic [HC_W-1:0] HS_END_C = HC_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HC_W-1:0] H_LAST_C = HC_W'(H_TOTAL - 1);
    localparam logic [VC_W-1:0] V_ACT_C  = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] VS_BEG_C = VC_W'(V_ACTIVE + V_FP);
    localparam logic [VC_W-1:0] VS_END_C = VC_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VC_W-1:0] V_LAST_C = VC_W'(V_TOTAL - 1);

    logic [HC_W-1:0]            h_cnt;
    logic [VC_W-1:0]            v_cnt;
    logic                       frame_px;
    logic                       active;
    logic                       hs_now;
    logic                       vs_now;
    logic [COORD_W-1:0]         col_now;
    logic [COORD_W-1:0]         row_now;

    logic [NUM_WIN-1:0]         en_s;
    logic [NUM_WIN*COORD_W-1:0] x0_s;
    logic [NUM_WIN*COORD_W-1:0] y0_s;
    logic [NUM_WIN*COORD_W-1:0] w_s;
    logic [NUM_WIN*COORD_W-1:0] h_s;
    logic [NUM_WIN-1:0]         cfg_en;
    logic [NUM_WIN*COORD_W-1:0] cfg_x0;
    logic [NUM_WIN*COORD_W-1:0] cfg_y0;
    logic [NUM_WIN*COORD_W-1:0] cfg_w;
    logic [NUM_WIN*COORD_W-1:0] cfg_h;

    logic [NUM_WIN-1:0]         hit;
    logic [SEL_W-1:0]           sel;
    logic [ADDR_W-1:0]          addr_cnt;
    logic [WADDR_W-1:0]         wcnt [NUM_WIN];
    logic                       started;

    assign frame_px = (h_cnt == '0) && (v_cnt == '0);
    assign active   = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign hs_now   = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
    assign vs_now   = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);
    assign col_now  = COORD_W'(h_cnt);
    assign row_now  = COORD_W'(v_cnt);

    // Pixel (0,0) already belongs to the new frame, so it sees the config being captured.
    assign cfg_en = frame_px ? win_en : en_s;
    assign cfg_x0 = frame_px ? win_x0 : x0_s;
    assign cfg_y0 = frame_px ? win_y0 : y0_s;
    assign cfg_w  = frame_px ? win_w  : w_s;
    assign cfg_h  = frame_px ? win_h  : h_s;

    // One extra bit on the upper bound keeps lo+len from wrapping.
    function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] len);
        logic [COORD_W:0] hi;
        hi = {1'b0, lo} + {1'b0, len};
        return (len != '0) && (pos >= lo) && ({1'b0, pos} < hi);
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_WIN; i++) begin
            hit[i] = active && cfg_en[i]
                && in_span(col_now, cfg_x0[i*COORD_W +: COORD_W], cfg_w[i*COORD_W +: COORD_W])
                && in_span(row_now, cfg_y0[i*COORD_W +: COORD_W], cfg_h[i*COORD_W +: COORD_W]);
        end
    end

    always_comb begin
        sel = '0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (hit[i]) sel = SEL_W'(i);
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST_C) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
            oHS         <= ~HS_POL;
            oVS         <= ~VS_POL;
            oBLANK_n    <= 1'b0;
            row         <= '0;
            col         <= '0;
            ADDR        <= '0;
            addr_cnt    <= '0;
            win_hit     <= '0;
            win_any     <= 1'b0;
            win_sel     <= '0;
            win_addr    <= '0;
            frame_start <= 1'b0;
            frame_count <= '0;
            started     <= 1'b0;
            en_s        <= '0;
            x0_s        <= '0;
            y0_s        <= '0;
            w_s         <= '0;
            h_s         <= '0;
            for (int i = 0; i < NUM_WIN; i++) wcnt[i] <= '0;
        end else begin
            oHS         <= hs_now ? HS_POL : ~HS_POL;
            oVS         <= vs_now ? VS_POL : ~VS_POL;
            oBLANK_n    <= active;
            frame_start <= frame_px;
            win_hit     <= hit;
            win_any     <= |hit;
            win_sel     <= sel;

            if (frame_px) begin
                en_s    <= win_en;
                x0_s    <= win_x0;
                y0_s    <= win_y0;
                w_s     <= win_w;
                h_s     <= win_h;
                started <= 1'b1;
                // The first frame after reset is frame 0; later starts count completed frames.
                if (started) frame_count <= frame_count + 1'b1;
            end

            if (active) begin
                row      <= row_now;
                col      <= col_now;
                ADDR     <= frame_px ? '0 : addr_cnt;
                addr_cnt <= frame_px ? ADDR_W'(1) : addr_cnt + 1'b1;
            end

            for (int i = 0; i < NUM_WIN; i++) begin
                if (hit[i]) begin
                    win_addr[i*WADDR_W +: WADDR_W] <= frame_px ? '0 : wcnt[i];
                    wcnt[i]                        <= frame_px ? WADDR_W'(1) : wcnt[i] + 1'b1;
                end else if (frame_px) begin
                    win_addr[i*WADDR_W +: WADDR_W] <= '0;
                    wcnt[i]                        <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench for vga_scan_controller on a reduced raster; expectations come
// from a pixel-index reference model that derives every output arithmetically.
module tb_vga_scan_controller;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 12, VFP = 1, VSY = 2, VBP = 2;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FT = HT * VT;
    localparam bit HSP = 1'b1;
    localparam bit VSP = 1'b0;
    localparam int NW = 4, CW = 6, AW = 19, WAW = 7, FW = 4;

    typedef struct {
        logic          hs, vs, blank;
        logic [CW-1:0] row, col;
        logic [AW-1:0] addr;
        logic [NW-1:0] hit;
        logic          any;
        logic [1:0]    sel;
        logic [NW*WAW-1:0] waddr;
        logic          fs;
        logic [FW-1:0] fc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset;
    logic [NW-1:0]     win_en;
    logic [NW*CW-1:0]  win_x0, win_y0, win_w, win_h;
    logic              oHS, oVS, oBLANK_n;
    logic [CW-1:0]     row, col;
    logic [AW-1:0]     ADDR;
    logic [NW-1:0]     win_hit;
    logic              win_any;
    logic [1:0]        win_sel;
    logic [NW*WAW-1:0] win_addr;
    logic              frame_start;
    logic [FW-1:0]     frame_count;

    vga_scan_controller #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(HSP), .VS_POL(VSP), .NUM_WIN(NW), .COORD_W(CW),
        .ADDR_W(AW), .WADDR_W(WAW), .FRAME_W(FW)
    ) dut (
        .iVGA_CLK(clk), .reset(reset),
        .win_en(win_en), .win_x0(win_x0), .win_y0(win_y0), .win_w(win_w), .win_h(win_h),
        .oHS(oHS), .oVS(oVS), .oBLANK_n(oBLANK_n), .row(row), .col(col), .ADDR(ADDR),
        .win_hit(win_hit), .win_any(win_any), .win_sel(win_sel), .win_addr(win_addr),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model state: position as a linear pixel index within the frame.
    int p, fc, lrow, lcol, laddr;
    bit started;
    int c_en[NW], c_x0[NW], c_y0[NW], c_w[NW], c_h[NW], lwa[NW];
    int rst_left;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    task automatic drive(input bit rst);
        exp_t e;
        int   h, v, xe;
        bit   act;
        reset = rst;
        if (rst) begin
            p = 0; fc = 0; started = 0; lrow = 0; lcol = 0; laddr = 0;
            for (int i = 0; i < NW; i++) lwa[i] = 0;
            e.hs = !HSP; e.vs = !VSP; e.blank = 0; e.fs = 0; e.fc = '0;
            e.hit = '0; e.any = 0; e.sel = '0;
        end else begin
            h = p % HT;
            v = p / HT;
            if (p == 0) begin
                for (int i = 0; i < NW; i++) begin
                    c_en[i] = win_en[i];
                    c_x0[i] = win_x0[i*CW +: CW];
                    c_y0[i] = win_y0[i*CW +: CW];
                    c_w[i]  = win_w[i*CW +: CW];
                    c_h[i]  = win_h[i*CW +: CW];
                    lwa[i]  = 0;
                end
                if (started) fc = (fc + 1) % (1 << FW);
                started = 1;
            end
            act     = (h < HA) && (v < VA);
            e.fs    = (p == 0);
            e.fc    = FW'(fc);
            e.blank = act;
            e.hs    = (h >= HA + HFP && h < HA + HFP + HSY) ? HSP : !HSP;
            e.vs    = (v >= VA + VFP && v < VA + VFP + VSY) ? VSP : !VSP;
            if (act) begin
                lrow = v; lcol = h; laddr = v * HA + h;
            end
            e.hit = '0; e.sel = '0;
            for (int i = NW - 1; i >= 0; i--) begin
                if (act && c_en[i] != 0 && c_w[i] > 0 && c_h[i] > 0 &&
                    h >= c_x0[i] && h < c_x0[i] + c_w[i] &&
                    v >= c_y0[i] && v < c_y0[i] + c_h[i]) begin
                    e.hit[i] = 1'b1;
                    e.sel    = 2'(i);
                    xe       = (c_x0[i] + c_w[i] < HA) ? c_x0[i] + c_w[i] : HA;
                    lwa[i]   = ((v - c_y0[i]) * (xe - c_x0[i]) + (h - c_x0[i])) % (1 << WAW);
                end
            end
            e.any = |e.hit;
            p = (p + 1) % FT;
        end
        e.row  = CW'(lrow);
        e.col  = CW'(lcol);
        e.addr = AW'(laddr);
        for (int i = 0; i < NW; i++) e.waddr[i*WAW +: WAW] = WAW'(lwa[i]);
        exp_q.push_back(e);
    endtask

    function automatic int rnd_coord(input int small_max);
        return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, (1 << CW) - 1))
                                           : int'($urandom_range(0, small_max));
    endfunction

    task automatic mutate();
        int i;
        i = $urandom_range(0, NW - 1);
        case ($urandom_range(0, 4))
            0: win_en[i] = ($urandom_range(0, 3) != 0);
            1: win_x0[i*CW +: CW] = CW'(rnd_coord(20));
            2: win_y0[i*CW +: CW] = CW'(rnd_coord(15));
            3: win_w[i*CW +: CW]  = CW'(rnd_coord(20));
            default: win_h[i*CW +: CW] = CW'(rnd_coord(15));
        endcase
    endtask

    task automatic set_win(input int i, input bit en, input int x0, input int y0, input int w, input int h);
        win_en[i] = en;
        win_x0[i*CW +: CW] = CW'(x0);
        win_y0[i*CW +: CW] = CW'(y0);
        win_w[i*CW +: CW]  = CW'(w);
        win_h[i*CW +: CW]  = CW'(h);
    endtask

    // Monitor: every clock produces one output vector; compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("oHS", 64'(oHS), 64'(e.hs));
                check("oVS", 64'(oVS), 64'(e.vs));
                check("oBLANK_n", 64'(oBLANK_n), 64'(e.blank));
                check("row", 64'(row), 64'(e.row));
                check("col", 64'(col), 64'(e.col));
                check("ADDR", 64'(ADDR), 64'(e.addr));
                check("win_hit", 64'(win_hit), 64'(e.hit));
                check("win_any", 64'(win_any), 64'(e.any));
                check("win_sel", 64'(win_sel), 64'(e.sel));
                check("win_addr", 64'(win_addr), 64'(e.waddr));
                check("frame_start", 64'(frame_start), 64'(e.fs));
                check("frame_count", 64'(frame_count), 64'(e.fc));
            end
        end
    end

    initial begin
        reset = 1'b1;
        // Overlapping pair, a zero-width window and one clipped at the bottom-right corner.
        set_win(0, 1'b1, 2, 2, 8, 6);
        set_win(1, 1'b1, 5, 4, 8, 6);
        set_win(2, 1'b1, 3, 3, 0, 5);
        set_win(3, 1'b1, 12, 9, 10, 10);

        repeat (3) begin @(negedge clk); drive(1'b1); end
        repeat (3 * FT) begin @(negedge clk); drive(1'b0); end

        // Reset in the middle of an active line.
        while (p != 6 * HT + 10) begin @(negedge clk); drive(1'b0); end
        repeat (3) begin @(negedge clk); drive(1'b1); end

        // Random mid-frame config changes; long enough for frame_count to wrap.
        repeat (20 * FT) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) mutate();
            drive(1'b0);
        end

        // Same plus occasional short resets at random positions.
        rst_left = 0;
        repeat (12 * FT) begin
            @(negedge clk);
            if (rst_left == 0 && $urandom_range(0, 1499) == 0) rst_left = $urandom_range(1, 3);
            if ($urandom_range(0, 149) == 0) mutate();
            drive(rst_left != 0);
            if (rst_left > 0) rst_left--;
        end

        @(posedge clk);
        #3;
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vga_scan_controller.md
Name: vga_scan_controller

Overview:
Parametrised successor to the VGA controller's raster front end. It generates HS/VS/BLANK timing for any resolution and derives row, col and a linear frame-buffer address from counters rather than divide/modulo. It also provides NUM_WIN rectangular overlay windows, each with its own local pixel-address counter for the trace, crest, digit and leaderboard ROMs. It sits between iVGA_CLK and the ROM/colour-select logic in the VGA top level.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, active level of oHS
VS_POL, 0, active level of oVS
NUM_WIN, 4, number of overlay windows
COORD_W, 10, coordinate width
ADDR_W, 19, frame-address width
WADDR_W, 18, window-address width
FRAME_W, 32, frame counter width

Ports:
iVGA_CLK  in  1  pixel clock; all logic on its rising edge
reset  in  1  synchronous, active-high
win_en  in  NUM_WIN  per-window enable
win_x0  in  NUM_WIN*COORD_W  packed left column, window i at [i*COORD_W +: COORD_W]
win_y0  in  NUM_WIN*COORD_W  packed top row
win_w  in  NUM_WIN*COORD_W  packed width in pixels
win_h  in  NUM_WIN*COORD_W  packed height in lines
oHS  out  1  horizontal sync
oVS  out  1  vertical sync
oBLANK_n  out  1  1 = active pixel
row  out  COORD_W  current active row
col  out  COORD_W  current active column
ADDR  out  ADDR_W  linear active-pixel index
win_hit  out  NUM_WIN  pixel inside window i
win_any  out  1  OR of win_hit
win_sel  out  clog2(NUM_WIN)  lowest-index hit window
win_addr  out  NUM_WIN*WADDR_W  packed local address per window
frame_start  out  1  one-cycle pulse at pixel (0,0)
frame_count  out  FRAME_W  completed-frame counter

Behaviour:
- Counters: h_cnt counts 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. v_cnt advances when h_cnt wraps and counts 0..V_TOTAL-1. Both wrap to 0.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- All outputs are registered with latency 1. The values on outputs in cycle n+1 describe the (h_cnt, v_cnt) held in cycle n, so every output is mutually aligned.
- oHS = HS_POL while h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); otherwise it is the inverse of HS_POL.
- oVS follows the same rule on v_cnt and applies for whole lines.
- row and col equal v_cnt and h_cnt during active pixels and hold their last values during blanking.
- ADDR is 0 at pixel (0,0) and increments by 1 per active pixel, so it equals row*H_ACTIVE+col. It holds during blanking. No multiplier or divider is used.
- Shadow registers: window config inputs are sampled into shadow registers only in the cycle where h_cnt=0 and v_cnt=0. Changes made mid-frame take effect at the next frame.
- Window hit: win_hit[i] = win_en_s[i] & w_s>0 & h_s>0 & x0 ≤ col < x0+w & y0 ≤ row < y0+h & active. Compares use COORD_W+1 bits so there is no overflow.
- Clipping: a window extending past the active area is clipped; only visible pixels hit.
- win_addr[i] is the local address of the current pixel. It is 0 at the first hit pixel of the frame and increments after each hit pixel. It resets to 0 at frame start regardless of the previous count.
  - For an unclipped window this gives win_addr = (row-y0)*w + (col-x0).
  - The value holds when not hit.
  - Overflow past 2^WADDR_W-1 wraps.
- win_sel is the lowest index i with win_hit[i]=1, or 0 if no window hits. win_any is the OR of win_hit.
- frame_start is 1 for exactly the output cycle that describes pixel (0,0). frame_count increments by 1 in that same cycle, wrapping at 2^FRAME_W, and is 0 at the first frame after reset.
- Reset (synchronous, any time, including mid-line): h_cnt and v_cnt are set to 0.
  - Outputs: oHS=~HS_POL, oVS=~VS_POL, oBLANK_n=0, row=col=ADDR=0, win_hit=0, win_any=0, win_sel=0, win_addr=0, frame_start=0, frame_count=0.
  - Shadow registers are cleared, so all windows are disabled.
  - The first cycle after reset deasserts processes pixel (0,0): shadow registers load and frame_start pulses, with frame_count staying 0 for that first pulse.

Test Plan:
- Default parameters, release reset:
  - frame_start at output cycle 1.
  - oHS low for 96 cycles, starting 656 cycles after each line's first pixel; line period 800.
  - oVS low for 2 lines, starting at line 490; frame period 420000 cycles.
  - frame_count = 1 at the second frame_start.
- ADDR sequence:
  - 639 at (row 0, col 639).
  - Held at 639 through blanking.
  - 640 at (row 1, col 0).
  - 307199 at (479, 639).
  - 0 at the next frame_start.
- Window 0 at x0=120, y0=40, w=400, h=400:
  - win_addr = 0 at (40,120), 399 at (40,519), 400 at (41,120), 159999 at (439,519).
  - win_hit = 0 at (439,520).
- Windows 0 (10,10,100,100) and 1 (50,50,100,100) overlapping:
  - At (60,60): win_hit=2'b11, win_sel=0.
  - At (120,120): win_sel=1.
  - Zero-width window 2: never hits.
- Change win_x0 mid-frame: hits follow the old value until frame_start, then the new value.
- Assert reset at (200,300) for 3 cycles: all outputs return to reset values, and the timing restarts from (0,0) with frame_count = 0.
